// File: rtl/minimization_pkg.sv
// Shared types and constants for the minimization pair-code decoder.
// The legal codewords are those the encoder can emit: o1 is always the inverse of o2.
package minimization_pkg;

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_LO  = 2'd1,
        S_OUT = 2'd2
    } state_t;

    localparam logic [2:0] CODE_00 = 3'b010;
    localparam logic [2:0] CODE_01 = 3'b101;
    localparam logic [2:0] CODE_10 = 3'b100;
    localparam logic [2:0] CODE_11 = 3'b011;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/minimization_decoder_if.sv
// Codeword input stream and digit output stream of the decoder.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
// valid and its payload hold until that edge, and ready may depend on state only.
interface minimization_decoder_if;

    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_err;
    logic       out_ready;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/minimization_pair_dec.sv
// Combinational decode of one codeword {o2,o1,o0} back to a bit pair.
// Illegal codes still decode by the same formula; only the flag tells them apart.
module minimization_pair_dec (
    input  logic [2:0] code_i,
    output logic [1:0] pair_o,
    output logic       illegal_o
);

    assign pair_o    = {code_i[2] ^ code_i[0], code_i[0]};
    assign illegal_o = (code_i[1] == code_i[2]);

endmodule

// File: rtl/minimization_decoder.sv
// Assembles two decoded codeword pairs into a 4-bit digit, flags illegal codes and
// non-BCD digits, and counts errored digits delivered downstream (saturating).
module minimization_decoder
    import minimization_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter bit BCD_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    minimization_decoder_if.slave bus,
    output logic [CNT_W-1:0]     err_cnt,
    output state_t               dbg_state_o
);

    state_t             state_q;
    logic [1:0]         hi_q;
    logic               err_q;
    logic               valid_q;
    logic [3:0]         data_q;
    logic               oerr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [1:0]         pair;
    logic               illegal;
    logic [3:0]         digit_d;
    logic               oerr_d;
    logic               accept;

    minimization_pair_dec u_pair_dec (
        .code_i    (bus.in_code),
        .pair_o    (pair),
        .illegal_o (illegal)
    );

    assign accept  = bus.in_valid & bus.in_ready;
    assign digit_d = {hi_q, pair};
    assign oerr_d  = err_q | illegal | (BCD_CHECK & (digit_d > BCD_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HI;
            hi_q    <= 2'b00;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            oerr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_HI: begin
                    if (accept) begin
                        hi_q    <= pair;
                        err_q   <= illegal;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        data_q  <= digit_d;
                        oerr_q  <= oerr_d;
                        valid_q <= 1'b1;
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    // Counter moves only on delivery, so a discarded digit never counts.
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_HI;
                        if (oerr_q && (cnt_q != {CNT_W{1'b1}})) begin
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_q <= S_HI;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q != S_OUT);
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_err   = oerr_q;
    assign err_cnt       = cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_minimization_decoder.sv
// Directed bench: three decoder instances (default, BCD check off, 2-bit counter)
// share one stimulus stream and are checked against hand-computed digits and counts.
module tb_minimization_decoder;
  import minimization_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'b000;
  logic       out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];

  minimization_decoder_if bus0 ();
  minimization_decoder_if bus1 ();
  minimization_decoder_if bus2 ();

  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  state_t     st0, st1, st2;

  assign bus0.in_valid = in_valid;  assign bus0.in_code = in_code;  assign bus0.out_ready = out_ready;
  assign bus1.in_valid = in_valid;  assign bus1.in_code = in_code;  assign bus1.out_ready = out_ready;
  assign bus2.in_valid = in_valid;  assign bus2.in_code = in_code;  assign bus2.out_ready = out_ready;

  minimization_decoder #(.CNT_W(8), .BCD_CHECK(1'b1)) dut_main (
    .clk(clk), .rst(rst), .bus(bus0), .err_cnt(cnt0), .dbg_state_o(st0));
  minimization_decoder #(.CNT_W(8), .BCD_CHECK(1'b0)) dut_nobcd (
    .clk(clk), .rst(rst), .bus(bus1), .err_cnt(cnt1), .dbg_state_o(st1));
  minimization_decoder #(.CNT_W(2), .BCD_CHECK(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2), .err_cnt(cnt2), .dbg_state_o(st2));

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] enc(input logic [1:0] p);
    return {p[1] ^ p[0], ~(p[1] ^ p[0]), p[0]};
  endfunction

  // driver: present a codeword and hold it until accepted
  task automatic send_code(input logic [2:0] c);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_code  = c;
    while (!bus0.in_ready && w < 20) begin
      step();
      w++;
    end
    check_eq("send_ready", 32'(bus0.in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // check a held digit, then complete the output handshake
  task automatic take(input string tag, input logic [3:0] d, input logic e0, input logic e1,
                      input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] c2);
    check_eq({tag, "_valid"}, 32'(bus0.out_valid), 32'd1);
    check_eq({tag, "_data"},  32'(bus0.out_data), 32'(d));
    check_eq({tag, "_err"},   32'(bus0.out_err), 32'(e0));
    check_eq({tag, "_data_nb"}, 32'(bus1.out_data), 32'(d));
    check_eq({tag, "_err_nb"},  32'(bus1.out_err), 32'(e1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_vld_drop"}, 32'(bus0.out_valid), 32'd0);
    check_eq({tag, "_cnt"},    32'(cnt0), 32'(c0));
    check_eq({tag, "_cnt_nb"}, 32'(cnt1), 32'(c1));
    check_eq({tag, "_cnt_sat"}, 32'(cnt2), 32'(c2));
  endtask

  initial begin
    logic [3:0] d;
    logic [3:0] e;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(bus0.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus0.out_data), 32'd0);
    check_eq("rst_out_err", 32'(bus0.out_err), 32'd0);
    check_eq("rst_cnt", 32'(cnt0), 32'd0);
    check_eq("rst_state", 32'(st0), 32'(S_HI));
    rst = 1'b0;
    step();

    // legal digit 9, valid visible right after the second accept
    send_code(CODE_10);
    check_eq("t1_no_early_valid", 32'(bus0.out_valid), 32'd0);
    send_code(CODE_01);
    take("t1", 4'd9, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);

    // sweep 0..9 back-to-back, in_ready low for exactly one cycle per digit
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = 4'(i);
      exp_q.push_back(d);
      send_code(enc(d[3:2]));
      send_code(enc(d[1:0]));
      e = exp_q.pop_front();
      check_eq("sw_in_ready_lo", 32'(bus0.in_ready), 32'd0);
      check_eq("sw_valid", 32'(bus0.out_valid), 32'd1);
      check_eq("sw_data", 32'(bus0.out_data), 32'(e));
      check_eq("sw_err", 32'(bus0.out_err), 32'd0);
      step();
      check_eq("sw_in_ready_hi", 32'(bus0.in_ready), 32'd1);
      check_eq("sw_valid_drop", 32'(bus0.out_valid), 32'd0);
    end
    out_ready = 1'b0;
    check_eq("sw_cnt", 32'(cnt0), 32'd0);

    // non-BCD digit 12: error only when the BCD check is enabled
    send_code(CODE_11);
    send_code(CODE_00);
    take("t3", 4'd12, 1'b1, 1'b0, 8'd1, 8'd0, 2'd1);

    // illegal high code with backpressure and a refused codeword during the stall
    send_code(3'b000);
    send_code(CODE_01);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        in_code  = CODE_00;
      end
      check_eq("t4_hold_in_ready", 32'(bus0.in_ready), 32'd0);
      check_eq("t4_hold_valid", 32'(bus0.out_valid), 32'd1);
      check_eq("t4_hold_data", 32'(bus0.out_data), 32'd1);
      check_eq("t4_hold_err", 32'(bus0.out_err), 32'd1);
      check_eq("t4_hold_cnt", 32'(cnt0), 32'd1);
      step();
      in_valid = 1'b0;
    end
    take("t4", 4'd1, 1'b1, 1'b1, 8'd2, 8'd1, 2'd2);
    check_eq("t4_state_after", 32'(st0), 32'(S_HI));

    // asynchronous reset discards a half-received digit and clears the counter
    send_code(CODE_10);
    check_eq("t5_state_lo", 32'(st0), 32'(S_LO));
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_async_state", 32'(st0), 32'(S_HI));
    check_eq("t5_async_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("t5_async_cnt", 32'(cnt0), 32'd0);
    check_eq("t5_async_cnt_sat", 32'(cnt2), 32'd0);
    step();
    rst = 1'b0;
    check_eq("t5_rst_valid", 32'(bus0.out_valid), 32'd0);
    send_code(CODE_00);
    send_code(CODE_01);
    take("t5", 4'd1, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0);

    // saturation of the 2-bit counter over five errored digits
    for (int i = 0; i < 5; i++) begin
      send_code(CODE_11);
      send_code(CODE_00);
      take("t6", 4'd12, 1'b1, 1'b0, 8'(i + 1), 8'd0, sat_exp[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
